// File: rtl/sp_stat_collector_if.sv
// Sample-in / summary-out bundle between SP and the statistics collector.
// master drives samples and the clock-gating hint; slave returns the summary stream.
interface sp_stat_collector_if #(
    parameter int DATA_W = 10
);
    logic                     in_valid;
    logic                     cg_en;
    logic signed [DATA_W-1:0] in_data;
    logic                     out_valid;
    logic signed [DATA_W-1:0] out_data;

    modport master (
        output in_valid,
        output cg_en,
        output in_data,
        input  out_valid,
        input  out_data
    );

    modport slave (
        input  in_valid,
        input  cg_en,
        input  in_data,
        output out_valid,
        output out_data
    );
endinterface

// File: rtl/sp_stat_collector.sv
// Burst statistics: emits count, max, min, saturated sum as 4 back-to-back words, word 0 one cycle after burst end.
// No backpressure: samples beyond MAX_LEN and samples arriving while the summary is being emitted are dropped.
module sp_stat_collector #(
    parameter int DATA_W  = 10,
    parameter int MAX_LEN = 16,
    parameter int ACC_W   = DATA_W + $clog2(MAX_LEN)
) (
    input  logic                clk,
    input  logic                rst_n,
    sp_stat_collector_if.slave  bus
);

    localparam int CNT_W = $clog2(MAX_LEN + 1);
    localparam logic signed [ACC_W-1:0] SUM_HI = ACC_W'((1 << (DATA_W - 1)) - 1);
    localparam logic signed [ACC_W-1:0] SUM_LO = ACC_W'(-(1 << (DATA_W - 1)));

    typedef enum logic [1:0] {
        IDLE,
        ACC,
        OUT
    } state_t;

    state_t                    r_state;
    logic [1:0]                r_idx;
    logic                      r_out_vld;
    logic signed [DATA_W-1:0]  r_out_dat;

    logic [CNT_W-1:0]          r_cnt;
    logic signed [DATA_W-1:0]  r_max;
    logic signed [DATA_W-1:0]  r_min;
    logic signed [ACC_W-1:0]   r_sum;

    logic [CNT_W-1:0]          w_cnt_nxt;
    logic signed [DATA_W-1:0]  w_max_nxt;
    logic signed [DATA_W-1:0]  w_min_nxt;
    logic signed [ACC_W-1:0]   w_sum_nxt;

    logic signed [DATA_W-1:0]  w_in;
    logic signed [ACC_W-1:0]   w_in_ext;
    logic signed [DATA_W-1:0]  w_sum_sat;
    logic                      w_take;
    logic                      w_acc_upd;
    logic                      w_ld_cnt;
    logic                      w_ld_max;
    logic                      w_ld_min;
    logic                      w_ld_sum;

    assign w_in     = bus.in_data;
    assign w_in_ext = {{(ACC_W - DATA_W){w_in[DATA_W-1]}}, w_in};

    // A burst may open from IDLE or on the very edge that retires word 3.
    assign w_take    = bus.in_valid &&
                       ((r_state == IDLE) || ((r_state == OUT) && (r_idx == 2'd3)));
    assign w_acc_upd = bus.in_valid && (r_state == ACC) && (r_cnt < CNT_W'(MAX_LEN));

    always_comb begin
        if (r_sum > SUM_HI) begin
            w_sum_sat = {1'b0, {(DATA_W - 1){1'b1}}};
        end else if (r_sum < SUM_LO) begin
            w_sum_sat = {1'b1, {(DATA_W - 1){1'b0}}};
        end else begin
            w_sum_sat = r_sum[DATA_W-1:0];
        end
    end

    always_comb begin
        w_cnt_nxt = r_cnt;
        w_max_nxt = r_max;
        w_min_nxt = r_min;
        w_sum_nxt = r_sum;
        if (w_take) begin
            w_cnt_nxt = CNT_W'(1);
            w_max_nxt = w_in;
            w_min_nxt = w_in;
            w_sum_nxt = w_in_ext;
        end else if (w_acc_upd) begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
            w_max_nxt = (w_in > r_max) ? w_in : r_max;
            w_min_nxt = (w_in < r_min) ? w_in : r_min;
            w_sum_nxt = r_sum + w_in_ext;
        end
    end

    // With the hint set, each accumulator loads only on a real change, giving synthesis a clean ICG enable.
    assign w_ld_cnt = !bus.cg_en || (w_cnt_nxt != r_cnt);
    assign w_ld_max = !bus.cg_en || (w_max_nxt != r_max);
    assign w_ld_min = !bus.cg_en || (w_min_nxt != r_min);
    assign w_ld_sum = !bus.cg_en || (w_sum_nxt != r_sum);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
            r_max <= '0;
            r_min <= '0;
            r_sum <= '0;
        end else begin
            if (w_ld_cnt) r_cnt <= w_cnt_nxt;
            if (w_ld_max) r_max <= w_max_nxt;
            if (w_ld_min) r_min <= w_min_nxt;
            if (w_ld_sum) r_sum <= w_sum_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_idx     <= 2'd0;
            r_out_vld <= 1'b0;
            r_out_dat <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_take) r_state <= ACC;
                end
                ACC: begin
                    if (!bus.in_valid) begin
                        r_state   <= OUT;
                        r_idx     <= 2'd0;
                        r_out_vld <= 1'b1;
                        r_out_dat <= DATA_W'(r_cnt);
                    end
                end
                OUT: begin
                    r_idx <= r_idx + 2'd1;
                    case (r_idx)
                        2'd0: r_out_dat <= r_max;
                        2'd1: r_out_dat <= r_min;
                        2'd2: r_out_dat <= w_sum_sat;
                        default: begin
                            r_out_vld <= 1'b0;
                            r_out_dat <= '0;
                            r_state   <= w_take ? ACC : IDLE;
                        end
                    endcase
                end
                default: begin
                    r_state   <= IDLE;
                    r_out_vld <= 1'b0;
                    r_out_dat <= '0;
                end
            endcase
        end
    end

    assign bus.out_valid = r_out_vld;
    assign bus.out_data  = r_out_dat;

endmodule

// File: tb/tb_sp_stat_collector.sv
// Self-checking bench for sp_stat_collector: directed bursts, resets and a randomized stream vs. a burst-level model.
module tb_sp_stat_collector;

    localparam int DW = 10;
    localparam int ML = 16;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    sp_stat_collector_if #(.DATA_W(DW)) bus ();

    sp_stat_collector #(
        .DATA_W  (DW),
        .MAX_LEN (ML),
        .ACC_W   (14)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    bit s_vld[$];
    int s_dat[$];
    bit exp_v[$];
    int exp_d[$];

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic add(input bit v, input int d);
        s_vld.push_back(v);
        s_dat.push_back(d);
    endtask

    task automatic add_idle(input int n);
        for (int i = 0; i < n; i++) add(1'b0, 0);
    endtask

    // Burst-level reference: gather samples per burst, then lay the 4 summary words onto the output timeline.
    task automatic build_expected();
        int n;
        bit in_burst;
        int free_at;
        int q[$];
        int w[4];
        int mx, mn, sm;
        n = s_vld.size();
        exp_v.delete();
        exp_d.delete();
        for (int k = 0; k < n; k++) begin
            exp_v.push_back(1'b0);
            exp_d.push_back(0);
        end
        in_burst = 1'b0;
        free_at  = 0;
        for (int k = 0; k < n; k++) begin
            if (in_burst) begin
                if (s_vld[k]) begin
                    if (q.size() < ML) q.push_back(s_dat[k]);
                end else begin
                    mx = q[0]; mn = q[0]; sm = 0;
                    foreach (q[i]) begin
                        if (q[i] > mx) mx = q[i];
                        if (q[i] < mn) mn = q[i];
                        sm += q[i];
                    end
                    w[0] = q.size();
                    w[1] = mx;
                    w[2] = mn;
                    w[3] = (sm > 511) ? 511 : ((sm < -512) ? -512 : sm);
                    for (int j = 0; j < 4; j++) begin
                        if (k + j < n) begin
                            exp_v[k + j] = 1'b1;
                            exp_d[k + j] = w[j];
                        end
                    end
                    in_burst = 1'b0;
                    free_at  = k + 4;
                end
            end else if (s_vld[k] && k >= free_at) begin
                in_burst = 1'b1;
                q.delete();
                q.push_back(s_dat[k]);
            end
        end
    endtask

    task automatic do_reset();
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_vld", bus.out_valid, 0);
        chk("rst_dat", $signed(bus.out_data), 0);
        rst_n = 1'b1;
    endtask

    // cg_mode: 0 = hint low, 1 = hint high, 2 = random every cycle
    task automatic run_stream(input string name, input int cg_mode, input bit with_reset);
        build_expected();
        if (with_reset) do_reset();
        for (int k = 0; k < s_vld.size(); k++) begin
            bus.in_valid = s_vld[k];
            bus.in_data  = DW'(s_dat[k]);
            bus.cg_en    = (cg_mode == 2) ? 1'($urandom_range(0, 1)) : 1'(cg_mode);
            @(posedge clk);
            #1;
            chk($sformatf("%s vld[%0d]", name, k), bus.out_valid, exp_v[k]);
            chk($sformatf("%s dat[%0d]", name, k), $signed(bus.out_data), exp_d[k]);
        end
        bus.in_valid = 1'b0;
        s_vld.delete();
        s_dat.delete();
    endtask

    task automatic build_b2b();
        add(1, 4); add(0, 0);
        add(1, 77); add(1, -30); add(1, 5);
        add(1, -1); add(1, 1); add(0, 0);
        add_idle(6);
    endtask

    initial begin
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        bus.cg_en    = 1'b0;

        add(1, 3); add(1, -5); add(1, 7); add_idle(6);
        run_stream("b357", 0, 1'b1);

        add(1, -512); add_idle(6);
        run_stream("single", 1, 1'b1);

        for (int i = 0; i < 16; i++) add(1, 511);
        add_idle(5);
        for (int i = 0; i < 16; i++) add(1, -512);
        add_idle(6);
        run_stream("sat", 2, 1'b1);

        for (int i = 0; i < 20; i++) add(1, -100);
        add_idle(6);
        run_stream("drop", 0, 1'b1);

        // Partial burst cut by async reset must leave no trace.
        do_reset();
        bus.in_valid = 1'b1;
        bus.in_data  = 10'sd9;
        @(posedge clk); #1;
        bus.in_data  = -10'sd3;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1 chk("midburst_rst_vld", bus.out_valid, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        add(1, 1); add(1, 2); add_idle(6);
        run_stream("after_rst", 0, 1'b0);

        // Reset during the summary drops out_valid without waiting for an edge.
        bus.in_valid = 1'b1;
        bus.in_data  = 10'sd5;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        @(posedge clk); #1;
        chk("midout_w0_vld", bus.out_valid, 1);
        chk("midout_w0_dat", $signed(bus.out_data), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("midout_rst_vld", bus.out_valid, 0);
        chk("midout_rst_dat", $signed(bus.out_data), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk($sformatf("midout_quiet[%0d]", i), bus.out_valid, 0);
        end

        build_b2b();
        run_stream("b2b_cg0", 0, 1'b1);
        build_b2b();
        run_stream("b2b_cgr", 2, 1'b1);

        for (int i = 0; i < 25; i++) add(1, int'($urandom_range(0, 1023)) - 512);
        for (int i = 0; i < 400; i++) add($urandom_range(0, 9) < 7, int'($urandom_range(0, 1023)) - 512);
        add_idle(6);
        run_stream("rand", 2, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
